// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking gate controller:
//   gate_state_t  - gate FSM state encoding
//   seg7_digit_t  - 7-segment pattern {g,f,e,d,c,b,a}, active-low
//   SEG7_0..9     - segment patterns for the decimal digits
//   seg7_encode() - BCD digit -> segment pattern (blank for 10..15)
// -----------------------------------------------------------------------------
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_PASSWORD = 3'd1,
        WRONG_PASS    = 3'd2,
        RIGHT_PASS    = 3'd3,
        FULL_STOP     = 3'd4,
        LOCKED        = 3'd5
    } gate_state_t;

    typedef logic [6:0] seg7_digit_t;

    localparam seg7_digit_t SEG7_0     = 7'b1000000;
    localparam seg7_digit_t SEG7_1     = 7'b1111001;
    localparam seg7_digit_t SEG7_2     = 7'b0100100;
    localparam seg7_digit_t SEG7_3     = 7'b0110000;
    localparam seg7_digit_t SEG7_4     = 7'b0011001;
    localparam seg7_digit_t SEG7_5     = 7'b0010010;
    localparam seg7_digit_t SEG7_6     = 7'b0000010;
    localparam seg7_digit_t SEG7_7     = 7'b1111000;
    localparam seg7_digit_t SEG7_8     = 7'b0000000;
    localparam seg7_digit_t SEG7_9     = 7'b0010000;
    localparam seg7_digit_t SEG7_BLANK = 7'b1111111;

    function automatic seg7_digit_t seg7_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG7_0;
            4'd1:    return SEG7_1;
            4'd2:    return SEG7_2;
            4'd3:    return SEG7_3;
            4'd4:    return SEG7_4;
            4'd5:    return SEG7_5;
            4'd6:    return SEG7_6;
            4'd7:    return SEG7_7;
            4'd8:    return SEG7_8;
            4'd9:    return SEG7_9;
            default: return SEG7_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl_if
// Lane-side bundle of the parking gate controller.
//   master (lane sensors / keypad side): drives sensor_entrance, sensor_exit,
//          sensor_depart, password, password_valid; observes the outputs.
//   slave  (controller): drives GREEN_LED, RED_LED, HEX_1 (tens), HEX_2 (units)
//          and full.
// -----------------------------------------------------------------------------
interface parking_gate_ctrl_if #(
    parameter int PW_WIDTH = 4
);
    import parking_pkg::*;

    logic                sensor_entrance;
    logic                sensor_exit;
    logic                sensor_depart;
    logic [PW_WIDTH-1:0] password;
    logic                password_valid;
    logic                GREEN_LED;
    logic                RED_LED;
    seg7_digit_t         HEX_1;
    seg7_digit_t         HEX_2;
    logic                full;

    modport master (
        output sensor_entrance, sensor_exit, sensor_depart, password, password_valid,
        input  GREEN_LED, RED_LED, HEX_1, HEX_2, full
    );

    modport slave (
        input  sensor_entrance, sensor_exit, sensor_depart, password, password_valid,
        output GREEN_LED, RED_LED, HEX_1, HEX_2, full
    );

endinterface

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to 7-segment decoder.
//   digit : 4-bit BCD digit (10..15 show blank)
//   seg   : segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg7_decode
    import parking_pkg::*;
(
    input  logic [3:0]  digit,
    output seg7_digit_t seg
);

    assign seg = seg7_encode(digit);

endmodule

// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
// Single entry gate with keypad password, lot occupancy tracking and a
// two-digit display of free spaces.
//   clk   : clock, everything on its rising edge
//   reset : synchronous, active-high
//   bus   : parking_gate_ctrl_if.slave (sensors, keypad, LEDs, HEX, full)
// Optional feature: define PARKING_LOCKOUT_EN to lock the gate for
// LOCK_CYCLES cycles after MAX_TRIES consecutive wrong passwords.
// -----------------------------------------------------------------------------
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int                  CAPACITY    = 8,
    parameter int                  PW_WIDTH    = 4,
    parameter logic [PW_WIDTH-1:0] PASSWORD    = 4'hA,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  LOCK_CYCLES = 16,
    parameter int                  WAIT_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    parking_gate_ctrl_if.slave bus
);

    localparam int OCC_W   = $clog2(CAPACITY + 1);
    localparam int CNT_MAX = (WAIT_CYCLES > LOCK_CYCLES) ? WAIT_CYCLES : LOCK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [OCC_W-1:0] CAP_OCC   = OCC_W'(CAPACITY);
    localparam logic [3:0]       CAP_TENS  = 4'(CAPACITY / 10);
    localparam logic [3:0]       CAP_UNITS = 4'(CAPACITY % 10);

    if (CAPACITY < 1 || CAPACITY > 99 || MAX_TRIES < 1) begin : g_param_check
        $error("parking_gate_ctrl: CAPACITY must be 1..99 and MAX_TRIES >= 1");
    end

    gate_state_t       state_reg, state_next;
    logic [OCC_W-1:0]  occ_reg, occ_next;
    logic [CNT_W-1:0]  timer_reg, timer_next;
    logic              exit_prev_reg, depart_prev_reg;
    logic              green_reg, green_next;
    logic              red_reg, red_next;
    logic              full_reg;
    seg7_digit_t       hex_1_reg, hex_2_reg;

`ifdef PARKING_LOCKOUT_EN
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    logic [TRY_W-1:0]  try_reg, try_next;
`endif

    logic exit_rise, depart_rise, entry_edge, pw_ok;
    int   free_int;

    logic [3:0]  free_digit [2];
    seg7_digit_t free_seg   [2];

    assign exit_rise   = bus.sensor_exit & ~exit_prev_reg;
    assign depart_rise = bus.sensor_depart & ~depart_prev_reg;
    // Only a car that was let through counts as an entry.
    assign entry_edge  = (state_reg == RIGHT_PASS) && exit_rise;
    assign pw_ok       = (bus.password == PASSWORD);

    // Occupancy: coincident entry and departure cancel out; both ends saturate.
    always_comb begin
        occ_next = occ_reg;
        if (entry_edge && !depart_rise && occ_reg != CAP_OCC)
            occ_next = occ_reg + 1'b1;
        else if (depart_rise && !entry_edge && occ_reg != '0)
            occ_next = occ_reg - 1'b1;
    end

    // Free-space digits come from the registered occupancy, so the display
    // trails occupancy by one cycle.
    always_comb begin
        free_int      = CAPACITY - int'(occ_reg);
        free_digit[0] = 4'(free_int / 10);
        free_digit[1] = 4'(free_int % 10);
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_seg
        seg7_decode u_seg7_decode (
            .digit (free_digit[gi]),
            .seg   (free_seg[gi])
        );
    end

    // Next-state logic. One timer serves every timed state; it restarts on
    // any state change, which gives each state its own fresh count.
    always_comb begin
        state_next = state_reg;
        timer_next = '0;
`ifdef PARKING_LOCKOUT_EN
        try_next   = try_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.sensor_entrance)
                    state_next = (occ_reg == CAP_OCC) ? FULL_STOP : WAIT_PASSWORD;
            end
            WAIT_PASSWORD, WRONG_PASS: begin
                if (bus.password_valid) begin
                    if (pw_ok) begin
                        state_next = RIGHT_PASS;
`ifdef PARKING_LOCKOUT_EN
                        try_next   = '0;
`endif
                    end else begin
`ifdef PARKING_LOCKOUT_EN
                        try_next   = try_reg + 1'b1;
                        state_next = (try_next == TRY_W'(MAX_TRIES)) ? LOCKED : WRONG_PASS;
`else
                        state_next = WRONG_PASS;
`endif
                    end
                end else if (timer_reg == CNT_W'(WAIT_CYCLES - 1)) begin
                    state_next = IDLE;
`ifdef PARKING_LOCKOUT_EN
                    try_next   = '0;
`endif
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RIGHT_PASS: begin
                if (entry_edge) begin
                    if (!bus.sensor_entrance)
                        state_next = IDLE;
                    else
                        state_next = (occ_next == CAP_OCC) ? FULL_STOP : WAIT_PASSWORD;
                end
            end
            FULL_STOP: begin
                if (!bus.sensor_entrance)
                    state_next = IDLE;
                else if (occ_next != CAP_OCC)
                    state_next = WAIT_PASSWORD;
            end
`ifdef PARKING_LOCKOUT_EN
            LOCKED: begin
                if (timer_reg == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_next = IDLE;
                    try_next   = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        if (state_next != state_reg)
            timer_next = '0;
    end

    // LEDs follow the state being entered so they register with it.
    always_comb begin
        green_next = 1'b0;
        red_next   = 1'b0;
        case (state_next)
            WAIT_PASSWORD: red_next   = 1'b1;
            WRONG_PASS:    red_next   = ~red_reg;
            RIGHT_PASS:    green_next = 1'b1;
            FULL_STOP:     red_next   = 1'b1;
            LOCKED:        red_next   = 1'b1;
            default:       red_next   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            occ_reg         <= '0;
            timer_reg       <= '0;
            exit_prev_reg   <= 1'b0;
            depart_prev_reg <= 1'b0;
            green_reg       <= 1'b0;
            red_reg         <= 1'b0;
            full_reg        <= 1'b0;
            hex_1_reg       <= seg7_encode(CAP_TENS);
            hex_2_reg       <= seg7_encode(CAP_UNITS);
`ifdef PARKING_LOCKOUT_EN
            try_reg         <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            occ_reg         <= occ_next;
            timer_reg       <= timer_next;
            exit_prev_reg   <= bus.sensor_exit;
            depart_prev_reg <= bus.sensor_depart;
            green_reg       <= green_next;
            red_reg         <= red_next;
            full_reg        <= (occ_next == CAP_OCC);
            hex_1_reg       <= free_seg[0];
            hex_2_reg       <= free_seg[1];
`ifdef PARKING_LOCKOUT_EN
            try_reg         <= try_next;
`endif
        end
    end

    assign bus.GREEN_LED = green_reg;
    assign bus.RED_LED   = red_reg;
    assign bus.full      = full_reg;
    assign bus.HEX_1     = hex_1_reg;
    assign bus.HEX_2     = hex_2_reg;

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Parametrised successor to the single-gate parking controller. It guards one entry gate with an N-bit password and tracks lot occupancy up to `CAPACITY`, decrementing on departures. It refuses entry when the lot is full and, optionally, locks out a driver after repeated wrong passwords. It drives the gate LEDs and a two-digit 7-segment display of free spaces, and sits between the lane sensors/keypad and the gate actuator.

## Interface
- `CAPACITY`, 8: lot size; 1..99.
- `PW_WIDTH`, 4: password width in bits.
- `PASSWORD`, 4'hA: accepted password, `PW_WIDTH` bits.
- `MAX_TRIES`, 3: consecutive wrong entries before lockout; ≥1.
- `LOCK_CYCLES`, 16: lockout duration in cycles.
- `WAIT_CYCLES`, 32: password timeout in cycles.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sensor_entrance` in 1: level; a car is waiting at the entry gate.
- `sensor_exit` in 1: level; a car is passing the entry gate. Its rising edge counts one entry.
- `sensor_depart` in 1: level; a car is leaving the lot. Its rising edge counts one departure.
- `password` in PW_WIDTH: keypad value.
- `password_valid` in 1: one-cycle strobe; `password` is sampled when it is high.
- `GREEN_LED` out 1: gate open.
- `RED_LED` out 1: gate closed/refused.
- `HEX_1` out 7: tens digit of free spaces.
- `HEX_2` out 7: units digit of free spaces. Encoding for both is {g,f,e,d,c,b,a}, active-low.
- `full` out 1: occupancy == CAPACITY.

## Operation
- **Edge detection:** registered previous values of `sensor_exit` and `sensor_depart`. Reset clears them to 0.
- **FSM states:** IDLE, WAIT_PASSWORD, WRONG_PASS, RIGHT_PASS, FULL_STOP, LOCKED.
- **IDLE:**
  - `sensor_entrance`=1 and occupancy<CAPACITY → WAIT_PASSWORD.
  - `sensor_entrance`=1 and occupancy==CAPACITY → FULL_STOP.
- **WAIT_PASSWORD / WRONG_PASS:**
  - `password_valid` with `password`==PASSWORD → RIGHT_PASS; clear the try counter.
  - `password_valid` with a mismatch → WRONG_PASS; increment the try counter.
  - Each state has its own timeout counter, reset on state entry and on every `password_valid`. WAIT_CYCLES cycles without `password_valid` → IDLE; clear the try counter.
- **RIGHT_PASS:**
  - Rising edge of `sensor_exit` increments occupancy.
  - In that same cycle: if `sensor_entrance`=1 and the new occupancy < CAPACITY → WAIT_PASSWORD.
  - If `sensor_entrance`=1 and the new occupancy == CAPACITY → FULL_STOP.
  - Otherwise → IDLE.
- **FULL_STOP:** stay until `sensor_entrance`=0 → IDLE, or occupancy drops below CAPACITY while `sensor_entrance`=1 → WAIT_PASSWORD.
- **LOCKED:** see Configuration.
- **Departures:** a rising edge of `sensor_depart` decrements occupancy in any state. Occupancy saturates at 0.
- **Simultaneous entry and departure edges:** occupancy is unchanged. An increment at CAPACITY cannot occur, because RIGHT_PASS is unreachable when the lot is full.
- **Widths:** occupancy is $clog2(CAPACITY+1) bits. Free = CAPACITY − occupancy, converted to tens/units by a constant divide (CAPACITY ≤ 99).
- **LEDs:**
  - IDLE: both off.
  - WAIT_PASSWORD: RED on.
  - WRONG_PASS: RED toggles every cycle, GREEN off.
  - RIGHT_PASS: GREEN on, RED off.
  - FULL_STOP and LOCKED: RED on.

## Timing
- All outputs are registered and update the cycle after the causing input edge. Occupancy and `full` update in the same edge as the FSM transition.
- HEX outputs lag occupancy by one cycle.
- Reset values:
  - State = IDLE; occupancy, try counter and timers = 0.
  - GREEN_LED = 0, RED_LED = 0, `full` = 0.
  - HEX_1/HEX_2 = encoded digits of CAPACITY (default: "0" = 7'b1000000, "8" = 7'b0000000).
- Reset asserted mid-operation aborts any state and clears occupancy to 0 on the next edge.
- A `password_valid` while in IDLE, RIGHT_PASS, FULL_STOP or LOCKED is ignored.

## Configuration
- **`PARKING_LOCKOUT_EN` defined:**
  - A mismatch that makes the try counter equal MAX_TRIES → LOCKED, not WRONG_PASS.
  - LOCKED lasts exactly LOCK_CYCLES cycles, ignores `password_valid`, then → IDLE with the try counter cleared.
- **Undefined:** no try counter and no LOCKED state. A mismatch always → WRONG_PASS, with unlimited retries.

## Structure
- `parking_pkg` holds:
  - the FSM state enum;
  - 7-segment digit constants for 0–9;
  - the `seg7_digit_t` typedef (7-bit).
- Sub-module `seg7_decode` maps a 4-bit BCD digit to active-low segments; it is instantiated twice.

## Test plan
Parameters: CAPACITY=2, PASSWORD=4'hA, MAX_TRIES=3, LOCK_CYCLES=16, WAIT_CYCLES=32, `PARKING_LOCKOUT_EN` defined.
- **Reset:** → GREEN=0, RED=0, full=0, HEX_1="0", HEX_2="2".
- **Normal entry:** `sensor_entrance`=1 → RED=1; `password`=4'hA with valid → GREEN=1; `sensor_exit` rise → occupancy 1, HEX_2="1", state IDLE.
- **Lockout:** three wrong `password`=4'h3 strobes → RED blinks after the first two, then steady RED for 16 cycles; a correct password in LOCKED is ignored; afterwards → IDLE.
- **Tailgating into a full lot:** fill to 2 with `sensor_entrance` held during the second pass → FULL_STOP, full=1, HEX="00"; `sensor_depart` rise → WAIT_PASSWORD, full=0, HEX_2="1".
- **Simultaneous edges:** `sensor_exit` and `sensor_depart` rise in the same cycle at occupancy 1 → occupancy stays 1.
- **Timeout and underflow:** WAIT_PASSWORD held 32 cycles with no valid → IDLE; `sensor_depart` at occupancy 0 → occupancy stays 0, HEX_2="2".
